// File: rtl/adl_spi_pkg.sv
// adl_spi_pkg: shared ADL5960 SPI frame fields, command struct and arbiter FSM states
package adl_spi_pkg;
  localparam int ADL_ADDR_W = 15;
  localparam int ADL_DATA_W = 8;
  localparam int ADL_CHIP_W = 2;
  typedef struct packed {
    logic                  rw;
    logic [ADL_CHIP_W-1:0] chip;
    logic [ADL_ADDR_W-1:0] addr;
    logic [ADL_DATA_W-1:0] wdata;
  } spi_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/adl_rr_arbiter.sv
// adl_rr_arbiter: combinational round-robin pick, searching upward from ptr and wrapping
module adl_rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_id = '0;
    idx = '0;
    // walk the ring backwards so the candidate closest to ptr is written last
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) gnt_id = idx;
    end
    gnt = |req ? {{(N-1){1'b0}}, 1'b1} << gnt_id : '0;
  end
endmodule

// File: rtl/adl_spi_arbiter.sv
// adl_spi_arbiter: round-robin sharing of one ADL5960 SPI engine, one transfer in flight,
// with start/timeout sequencing and response routing back to the granted requester.
module adl_spi_arbiter
  import adl_spi_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int CHIP_W = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = $clog2(N_REQ),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*CHIP_W-1:0] req_chip,
  input  logic [N_REQ*15-1:0]     req_addr,
  input  logic [N_REQ*8-1:0]      req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic                    spi_abort,
  output logic                    spi_rw,
  output logic [CHIP_W-1:0]       spi_chip,
  output logic [14:0]             spi_addr,
  output logic [7:0]              spi_wdata,
  input  logic                    spi_done,
  input  logic [7:0]              spi_rdata,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);
  state_t state_q, state_d;
  spi_cmd_t cmd_q, cmd_d, cmd_sel;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [TW-1:0] cnt_q, cnt_d;
  logic abort_q, abort_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  adl_rr_arbiter #(.N(N_REQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt), .gnt_id(gnt_id));
  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) cmd_sel = '{rw: req_rw[i], chip: ADL_CHIP_W'(req_chip[i*CHIP_W +: CHIP_W]),
                             addr: req_addr[i*ADL_ADDR_W +: ADL_ADDR_W],
                             wdata: req_wdata[i*ADL_DATA_W +: ADL_DATA_W]};
    state_d = state_q;
    cmd_d = cmd_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    cnt_d = cnt_q + TW'(1);
    abort_d = 1'b0;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = ISSUE;
        cmd_d = cmd_sel;
        gid_d = gnt_id;
        cnt_d = '0;
      end
      ISSUE: state_d = WAIT;
      // done is checked first so a completion on the last allowed cycle is not aborted
      WAIT: if (spi_done) begin
        state_d = RESP;
        rdata_d = cmd_q.rw ? spi_rdata : '0;
        err_d = 1'b0;
      end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        abort_d = 1'b1;
        rdata_d = '0;
        err_d = 1'b1;
      end
      RESP: if (rsp_ready[gid_q]) begin
        state_d = IDLE;
        ptr_d = (gid_q == IW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      cmd_q <= '0;
      ptr_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      abort_q <= abort_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_ready = (state_q == IDLE && ARESETN) ? gnt : '0;
  assign rsp_valid = (state_q == RESP) ? {{(N_REQ-1){1'b0}}, 1'b1} << gid_q : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign spi_start = state_q == ISSUE;
  assign spi_abort = abort_q;
  assign spi_rw = cmd_q.rw;
  assign spi_chip = cmd_q.chip[CHIP_W-1:0];
  assign spi_addr = cmd_q.addr;
  assign spi_wdata = cmd_q.wdata;
  assign busy = state_q != IDLE;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_adl_spi_arbiter.sv
// tb_adl_spi_arbiter: scoreboard bench; stimulus queues expected grants/responses from a
// rotation model, independent monitors compare them when the DUT starts or responds.
module tb_adl_spi_arbiter;
  localparam int N = 3, CW = 2, TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [N*CW-1:0] req_chip;
  logic [N*15-1:0] req_addr;
  logic [N*8-1:0] req_wdata;
  logic [7:0] rsp_rdata, spi_wdata, spi_rdata;
  logic rsp_err, spi_start, spi_abort, spi_rw, spi_done, busy;
  logic [CW-1:0] spi_chip;
  logic [14:0] spi_addr;
  logic [1:0] grant_id;

  adl_spi_arbiter #(.N_REQ(N), .CHIP_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(clk), .ARESETN(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_chip(req_chip), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .spi_start(spi_start),
    .spi_abort(spi_abort), .spi_rw(spi_rw), .spi_chip(spi_chip), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_done(spi_done), .spi_rdata(spi_rdata), .busy(busy),
    .grant_id(grant_id));

  always #5 clk = ~clk;

  typedef struct {
    int g;
    logic rw;
    logic [CW-1:0] chip;
    logic [14:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic err;
  } exp_t;
  exp_t cmd_q[$], rsp_q[$];
  logic rw_a[N];
  logic [CW-1:0] chip_a[N];
  logic [14:0] addr_a[N];
  logic [7:0] wdata_a[N];
  int vectors = 0, errs = 0, mptr = 0, cyc = 0, start_cyc = 0;
  logic acc_prev = 1'b0, low_prev = 1'b0, abort_seen = 1'b0, cur_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // next owner: first valid requester found going round the ring from the pointer
  function automatic int model_grant(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(mptr + k) % N]) return (mptr + k) % N;
    return 0;
  endfunction

  task automatic rand_cmds;
    for (int i = 0; i < N; i++) begin
      rw_a[i] = 1'($urandom);
      chip_a[i] = CW'($urandom);
      addr_a[i] = 15'($urandom);
      wdata_a[i] = 8'($urandom);
    end
  endtask

  task automatic drive_req(input logic [N-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_rw[i] = rw_a[i];
      req_chip[i*CW +: CW] = chip_a[i];
      req_addr[i*15 +: 15] = addr_a[i];
      req_wdata[i*8 +: 8] = wdata_a[i];
    end
  endtask

  // lat = cycles from spi_start to spi_done (0 = engine never answers)
  task automatic push_exp(input logic [N-1:0] mask, input int lat, input logic [7:0] rd, output int g);
    exp_t e;
    g = model_grant(mask);
    e.g = g;
    e.rw = rw_a[g];
    e.chip = chip_a[g];
    e.addr = addr_a[g];
    e.wdata = wdata_a[g];
    e.err = (lat == 0 || lat >= TO);
    e.rdata = (e.err || !e.rw) ? 8'h00 : rd;
    cmd_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  task automatic run_txn(input logic [N-1:0] mask, input int lat, input logic [7:0] rd,
                         input int bp, input bit hold);
    int g, n;
    push_exp(mask, lat, rd, g);
    drive_req(mask);
    n = 0;
    while (spi_start !== 1'b1 && n < 100) begin tick; n++; end
    chk("start_seen", spi_start, 1);
    if (!hold) req_valid[g] = 1'b0;
    if (lat > 0) begin
      repeat (lat) tick;
      spi_done = 1'b1;
      spi_rdata = rd;
      tick;
      spi_done = 1'b0;
      spi_rdata = 8'($urandom);
    end
    n = 0;
    while (rsp_valid == '0 && n < 100) begin tick; n++; end
    chk("rsp_seen", |rsp_valid, 1);
    repeat (bp) tick;
    rsp_ready = '1;
    tick;
    rsp_ready = '0;
    mptr = (g + 1) % N;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
      low_prev = 1'b0;
      abort_seen = 1'b0;
    end else begin
      exp_t e;
      if (acc_prev || spi_start) chk("start_timing", spi_start, acc_prev);
      acc_prev = |(req_valid & req_ready);
      if (acc_prev) begin
        if (cmd_q.size() == 0) chk("accept_unexpected", req_ready, 0);
        else chk("grant_onehot", req_ready, 64'(1) << cmd_q[0].g);
      end
      if (spi_start) begin
        if (cmd_q.size() == 0) chk("start_unexpected", spi_start, 0);
        else begin
          e = cmd_q.pop_front();
          chk("spi_fields", {spi_rw, spi_chip, spi_addr, spi_wdata}, {e.rw, e.chip, e.addr, e.wdata});
          chk("grant_id", grant_id, e.g);
          start_cyc = cyc;
          cur_err = e.err;
          abort_seen = 1'b0;
        end
      end
      if (spi_abort) begin
        abort_seen = 1'b1;
        chk("abort_delay", cyc - start_cyc, TO);
        chk("abort_expected", spi_abort, cur_err);
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = rsp_q[0];
          chk("rsp_valid", rsp_valid, 64'(1) << e.g);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("spi_hold", {spi_rw, spi_chip, spi_addr, spi_wdata}, {e.rw, e.chip, e.addr, e.wdata});
          chk("ready_in_resp", req_ready, 0);
          if (|(rsp_valid & rsp_ready)) begin
            chk("abort_seen", abort_seen, e.err);
            void'(rsp_q.pop_front());
          end
        end
      end
      if (low_prev && req_valid != '0) chk("busy_gap", busy, 1);
      low_prev = (req_valid != '0) && !busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    req_valid = '1;
    rsp_ready = '0;
    spi_done = 1'b0;
    spi_rdata = 8'h00;
    rand_cmds;
    drive_req('1);
    repeat (3) tick;
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_err, spi_start, spi_abort, busy, grant_id}, 0);
    chk("reset_data", {spi_rw, spi_chip, spi_addr, spi_wdata, rsp_rdata}, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick;
    // single write, requester 0
    rand_cmds;
    rw_a[0] = 1'b0; chip_a[0] = 2'd1; addr_a[0] = 15'h0021; wdata_a[0] = 8'h5A;
    run_txn(3'b001, 12, 8'hEE, 0, 0);
    // read, requester 2
    rand_cmds;
    rw_a[2] = 1'b1; addr_a[2] = 15'h0004;
    run_txn(3'b100, 7, 8'hC3, 0, 0);
    // contention: everyone stays valid for six transfers
    for (int t = 0; t < 6; t++) run_txn(3'b111, 3 + t, 8'($urandom), 0, 1);
    // engine never answers
    rand_cmds;
    run_txn(3'b001, 0, 8'h00, 0, 0);
    // response backpressure on requester 1 while it keeps requesting
    rand_cmds;
    rw_a[1] = 1'b1;
    run_txn(3'b010, 4, 8'h96, 10, 1);
    // done on the last allowed cycle, then one cycle too late
    rand_cmds;
    rw_a[2] = 1'b1;
    run_txn(3'b100, TO - 1, 8'h3C, 0, 0);
    rand_cmds;
    rw_a[0] = 1'b1;
    run_txn(3'b001, TO, 8'h81, 0, 0);
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int r, lat;
      rand_cmds;
      r = $urandom_range(9, 0);
      lat = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(TO - 2, 1);
      if ($urandom_range(3, 0) == 0) begin
        req_valid = '0;
        repeat ($urandom_range(3, 1)) tick;
      end
      run_txn(N'($urandom_range(7, 1)), lat, 8'($urandom), $urandom_range(3, 0), 0);
    end
    // reset while waiting on the engine
    rand_cmds;
    req_valid = '0;
    push_exp(3'b010, 0, 8'h00, g);
    drive_req(3'b010);
    for (int n = 0; n < 100 && spi_start !== 1'b1; n++) tick;
    req_valid = '0;
    repeat (3) tick;
    rst_n = 1'b0;
    req_valid = 3'b011;
    #1;
    chk("midreset_ctrl", {req_ready, rsp_valid, rsp_err, spi_start, spi_abort, busy, grant_id}, 0);
    chk("midreset_data", {spi_rw, spi_chip, spi_addr, spi_wdata, rsp_rdata}, 0);
    cmd_q.delete();
    rsp_q.delete();
    mptr = 0;
    repeat (2) tick;
    rst_n = 1'b1;
    rand_cmds;
    run_txn(3'b011, 5, 8'($urandom), 0, 0);
    rand_cmds;
    run_txn(3'b011, 2, 8'($urandom), 0, 0);
    req_valid = '0;
    repeat (4) tick;
    chk("queues_drained", cmd_q.size() + rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
